// File: rtl/a_jul_j.sv
// a_jul_j: 4-bit even-only up/down counter built from four T flip-flops.
//   Counts 0,2,4,...,14 and wraps at both ends; the direction comes from Y.
//   Q0 is held by a flip-flop whose toggle input is tied low, so it stays 0
//   once reset has been applied.
// Ports (positional order is fixed because instances connect by position):
//   Q3..Q0  out  raw flip-flop states, Q3 is the MSB
//   Y       in   direction: 0 = count up, 1 = count down
//   reset   in   synchronous, active-high; clears all four flip-flops
//   clk     in   rising-edge clock

// T flip-flop with synchronous active-high reset.
// Ports: clk, reset, t (1 = toggle on the next edge), q (state).
module tff (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= 1'b0;
    else if (t)
      q <= ~q;
  end

endmodule

module a_jul_j (
  output logic Q3,
  output logic Q2,
  output logic Q1,
  output logic Q0,
  input  logic Y,
  input  logic reset,
  input  logic clk
);

  wire y_n;
  wire q1_n;
  wire q2_n;
  wire t2_up;
  wire t2_dn;
  wire t2;
  wire t3_up;
  wire t3_dn;
  wire t3;

  not g_y_n  (y_n,  Y);
  not g_q1_n (q1_n, Q1);
  not g_q2_n (q2_n, Q2);

  // Bit 2 toggles when bit 1 carries (up) or borrows (down).
  and g_t2_up (t2_up, y_n, Q1);
  and g_t2_dn (t2_dn, Y, q1_n);
  or  g_t2    (t2, t2_up, t2_dn);

  // Bit 3 toggles when both lower counting bits carry (up) or borrow (down).
  and g_t3_up (t3_up, y_n, Q1, Q2);
  and g_t3_dn (t3_dn, Y, q1_n, q2_n);
  or  g_t3    (t3, t3_up, t3_dn);

  // Q0 never toggles; Q1 toggles every edge because the step is 2.
  tff u_tff0 (.clk(clk), .reset(reset), .t(1'b0), .q(Q0));
  tff u_tff1 (.clk(clk), .reset(reset), .t(1'b1), .q(Q1));
  tff u_tff2 (.clk(clk), .reset(reset), .t(t2),   .q(Q2));
  tff u_tff3 (.clk(clk), .reset(reset), .t(t3),   .q(Q3));

endmodule

// File: tb/tb_a_jul_j.sv
module tb_a_jul_j;

  logic clk;
  logic reset;
  logic Y;
  logic Q3, Q2, Q1, Q0;
  logic [3:0] q;

  int errors = 0;
  int checks = 0;
  int model  = 0;

  a_jul_j dut (
    .Q3(Q3), .Q2(Q2), .Q1(Q1), .Q0(Q0),
    .Y(Y), .reset(reset), .clk(clk)
  );

  assign q = {Q3, Q2, Q1, Q0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock step: drive inputs away from the edge, advance the reference
  // model by the counter's rule, then compare after the edge.
  task automatic step(input logic y, input logic r, input string tag);
    Y = y;
    reset = r;
    @(posedge clk);
    #1;
    if (r)
      model = 0;
    else if (y)
      model = (model + 16 - 2) % 16;
    else
      model = (model + 2) % 16;
    check(tag, q, 4'(model));
    check({tag, "_q0"}, {3'b000, Q0}, 4'b0000);
  endtask

  initial begin
    Y = 1'b0;
    reset = 1'b0;
    #2;

    step(1'b0, 1'b1, "reset_first");
    check("reset_lit", q, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "reset_hold");

    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "up_sweep");
    check("up_wrap_lit", q, 4'b0000);

    step(1'b1, 1'b0, "down_sweep");
    check("down_first_lit", q, 4'b1110);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, "down_sweep");
    check("down_wrap_lit", q, 4'b0000);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "flip_up");
    check("flip_at_0110", q, 4'b0110);
    step(1'b1, 1'b0, "flip_down");
    check("flip_lit1", q, 4'b0100);
    step(1'b1, 1'b0, "flip_down");
    check("flip_lit2", q, 4'b0010);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "to_1010");
    check("at_1010", q, 4'b1010);
    step(1'b0, 1'b1, "mid_reset");
    check("mid_reset_lit", q, 4'b0000);
    step(1'b0, 1'b0, "after_reset");
    check("after_reset_lit", q, 4'b0010);

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
